// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control bundle between the PC sequencer (master) and the
// datapath it steers (slave): opcode/zero/mem_ready in, enables and selects out.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWre;
  logic [1:0]       PCSrc;
  logic             IRWre;
  logic             RegWre;
  logic             RegDst;
  logic             ALUSrcB;
  logic             MemToReg;
  logic             MemRd;
  logic             MemWr;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, MemToReg,
           MemRd, MemWr, state, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, MemToReg,
           MemRd, MemWr, state, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle IF/ID/EXE/MEM/WB control FSM for the MIPS core.
// Drives PC, IR, register-file and data-memory enables, stalls in MEM until
// mem_ready, and counts retired instructions (one per PCWre pulse).
// Optional macro PC_SEQ_HALT_EN: the halt opcode parks the FSM in HALT until
// reset; without it halt decodes as an unknown opcode (2-cycle NOP).
module pc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  pc_sequencer_if.master bus
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
`ifdef PC_SEQ_HALT_EN
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;
`endif

  localparam logic [1:0] SRC_PC4 = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_J   = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
`ifdef PC_SEQ_HALT_EN
    S_WB   = 3'b100,
    S_HALT = 3'b111
`else
    S_WB   = 3'b100
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_halt;
  logic is_known, br_taken, decode_on;
  logic pc_wre, ir_wre, reg_wre, reg_dst, alu_src_b, mem_to_reg, mem_rd, mem_wr;
  logic [1:0] pc_src;

  // Opcode decode from the instruction register field.
  always_comb begin
    is_r     = (bus.opcode == OP_R);
    is_addi  = (bus.opcode == OP_ADDI);
    is_ori   = (bus.opcode == OP_ORI);
    is_lw    = (bus.opcode == OP_LW);
    is_sw    = (bus.opcode == OP_SW);
    is_beq   = (bus.opcode == OP_BEQ);
    is_bne   = (bus.opcode == OP_BNE);
    is_j     = (bus.opcode == OP_J);
`ifdef PC_SEQ_HALT_EN
    is_halt  = (bus.opcode == OP_HALT);
`else
    is_halt  = 1'b0;
`endif
    is_known = is_r | is_addi | is_ori | is_lw | is_sw | is_beq | is_bne | is_j | is_halt;
    br_taken = (is_beq & bus.zero) | (is_bne & ~bus.zero);
  end

  // State register and retired-instruction counter; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_wre) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and control outputs for the current step.
  always_comb begin
    state_d    = state_q;
    decode_on  = 1'b0;
    pc_wre     = 1'b0;
    pc_src     = SRC_PC4;
    ir_wre     = 1'b0;
    reg_wre    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src_b  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        decode_on = 1'b1;
        if (is_j) begin
          pc_wre  = 1'b1;
          pc_src  = SRC_J;
          state_d = S_IF;
        end else if (is_halt) begin
`ifdef PC_SEQ_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end else if (!is_known) begin
          pc_wre  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        decode_on = 1'b1;
        if (is_beq || is_bne) begin
          pc_wre  = 1'b1;
          pc_src  = br_taken ? SRC_BR : SRC_PC4;
          state_d = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        decode_on = 1'b1;
        mem_rd    = is_lw;
        mem_wr    = is_sw;
        if (bus.mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            pc_wre  = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        decode_on = 1'b1;
        reg_wre   = 1'b1;
        pc_wre    = 1'b1;
        state_d   = S_IF;
      end
`ifdef PC_SEQ_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IF;
      end
    endcase
    if (decode_on) begin
      reg_dst    = is_r;
      alu_src_b  = is_addi | is_ori | is_lw | is_sw;
      mem_to_reg = is_lw;
    end
  end

  // Drive the bundle.
  assign bus.PCWre    = pc_wre;
  assign bus.PCSrc    = pc_src;
  assign bus.IRWre    = ir_wre;
  assign bus.RegWre   = reg_wre;
  assign bus.RegDst   = reg_dst;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.MemToReg = mem_to_reg;
  assign bus.MemRd    = mem_rd;
  assign bus.MemWr    = mem_wr;
  assign bus.state    = state_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed instruction sequences; each driven cycle pushes
// its expected state/controls/retired into a scoreboard that a negedge
// monitor pops and compares.
module tb_pc_sequencer;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  pc_sequencer_if #(.CNT_W(32)) bus();
  pc_sequencer #(.CNT_W(32)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  typedef struct packed {
    logic [2:0]  st;
    logic [9:0]  ctrl;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_ret = '0;
  int          checks = 0;
  int          failures = 0;

  // ctrl = {PCWre, PCSrc[1:0], IRWre, RegWre, RegDst, ALUSrcB, MemToReg, MemRd, MemWr}
  localparam logic [9:0] C_IF = 10'b0001000000;
  localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
                         S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b111;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_HALT = 6'b111111;

  // One cycle: drive inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [2:0] st, input logic [9:0] c);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset         = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    e.st   = st;
    e.ctrl = c;
    e.ret  = exp_ret;
    sb.push_back(e);
    if (c[9]) exp_ret = exp_ret + 32'd1;
    if (!r) exp_ret = '0;
  endtask

  task automatic run_alu(input logic [5:0] op, input logic [9:0] dec, input logic [9:0] wb);
    cyc(1, op, 0, 0, S_IF, C_IF);
    cyc(1, op, 0, 0, S_ID, dec);
    cyc(1, op, 0, 0, S_EXE, dec);
    cyc(1, op, 0, 0, S_WB, wb);
  endtask

  task automatic run_two(input logic [5:0] op, input logic [9:0] id_c);
    cyc(1, op, 0, 0, S_IF, C_IF);
    cyc(1, op, 0, 0, S_ID, id_c);
  endtask

  task automatic run_br(input logic [5:0] op, input logic z, input logic [9:0] exe_c);
    cyc(1, op, 0, 0, S_IF, C_IF);
    cyc(1, op, 0, 0, S_ID, 10'b0000000000);
    cyc(1, op, z, 0, S_EXE, exe_c);
  endtask

  task automatic run_lw(input int waits);
    cyc(1, OP_LW, 0, 0, S_IF, C_IF);
    cyc(1, OP_LW, 0, 0, S_ID, 10'b0000001100);
    cyc(1, OP_LW, 0, 0, S_EXE, 10'b0000001100);
    for (int i = 0; i < waits; i++) cyc(1, OP_LW, 0, 0, S_MEM, 10'b0000001110);
    cyc(1, OP_LW, 0, 1, S_MEM, 10'b0000001110);
    cyc(1, OP_LW, 0, 0, S_WB, 10'b1000101100);
  endtask

  task automatic run_sw(input int waits);
    cyc(1, OP_SW, 0, 0, S_IF, C_IF);
    cyc(1, OP_SW, 0, 0, S_ID, 10'b0000001000);
    cyc(1, OP_SW, 0, 0, S_EXE, 10'b0000001000);
    for (int i = 0; i < waits; i++) cyc(1, OP_SW, 0, 0, S_MEM, 10'b0000001001);
    cyc(1, OP_SW, 0, 1, S_MEM, 10'b1000001001);
  endtask

  // Monitor: compare every queued cycle against the DUT on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    logic [9:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {bus.PCWre, bus.PCSrc, bus.IRWre, bus.RegWre, bus.RegDst,
             bus.ALUSrcB, bus.MemToReg, bus.MemRd, bus.MemWr};
      checks++;
      if (bus.state !== e.st) begin
        failures++;
        $display("FAIL state t=%0t actual=%b required=%b", $time, bus.state, e.st);
      end
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl t=%0t state=%b actual=%b required=%b", $time, e.st, act, e.ctrl);
      end
      checks++;
      if (bus.retired !== e.ret) begin
        failures++;
        $display("FAIL retired t=%0t actual=%0d required=%0d", $time, bus.retired, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    Reset         = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);

    run_alu(OP_R,    10'b0000010000, 10'b1000110000);
    run_alu(OP_ADDI, 10'b0000001000, 10'b1000101000);
    run_alu(OP_ORI,  10'b0000001000, 10'b1000101000);
    run_br(OP_BEQ, 1'b1, 10'b1010000000);
    run_br(OP_BNE, 1'b1, 10'b1000000000);
    run_br(OP_BNE, 1'b0, 10'b1010000000);
    run_br(OP_BEQ, 1'b0, 10'b1000000000);
    run_two(OP_J, 10'b1100000000);
    run_two(6'b111000, 10'b1000000000);
    run_lw(2);
    run_sw(0);
    run_lw(0);
    run_sw(1);

    // Reset while lw waits in MEM.
    cyc(1, OP_LW, 0, 0, S_IF, C_IF);
    cyc(1, OP_LW, 0, 0, S_ID, 10'b0000001100);
    cyc(1, OP_LW, 0, 0, S_EXE, 10'b0000001100);
    cyc(1, OP_LW, 0, 0, S_MEM, 10'b0000001110);
    cyc(0, OP_LW, 0, 0, S_MEM, 10'b0000001110);
    run_alu(OP_R, 10'b0000010000, 10'b1000110000);

`ifdef PC_SEQ_HALT_EN
    cyc(1, OP_HALT, 0, 0, S_IF, C_IF);
    cyc(1, OP_HALT, 0, 0, S_ID, 10'b0000000000);
    for (int i = 0; i < 12; i++) cyc(1, OP_HALT, i[0], 1, S_HALT, 10'b0000000000);
    cyc(0, OP_HALT, 0, 0, S_HALT, 10'b0000000000);
    run_two(OP_J, 10'b1100000000);
`else
    run_two(OP_HALT, 10'b1000000000);
    run_two(OP_J, 10'b1100000000);
`endif

    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
